// File: rtl/vga_pixel_fetch_if.sv
// Bundle of the signals between the pixel fetch engine, the memory read port and the display.
// The slave side is the fetch engine; the master side is the memory/display environment.
interface vga_pixel_fetch_if;
  logic        enable;
  logic        frame_start;
  logic        pix_rd;
  logic [15:0] vga_data;
  logic [14:0] vga_addr;
  logic [7:0]  pixel;
  logic        pix_valid;
  logic        underrun;

  modport master (
    output enable, frame_start, pix_rd, vga_data,
    input  vga_addr, pixel, pix_valid, underrun
  );

  modport slave (
    input  enable, frame_start, pix_rd, vga_data,
    output vga_addr, pixel, pix_valid, underrun
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Framebuffer read engine: streams one frame of 16-bit words into a small FIFO and
// hands them to the display as two rrr_ggg_bb pixels each, flagging any underrun.
module vga_pixel_fetch #(
  parameter int          H_PIX      = 320,
  parameter int          V_PIX      = 200,
  parameter logic [14:0] BASE_ADDR  = 15'h0,
  parameter int          FIFO_DEPTH = 8
) (
  input logic              clk,
  input logic              reset,
  vga_pixel_fetch_if.slave bus
);
  localparam int            FRAME_WORDS = H_PIX * V_PIX / 2;
  localparam int            PW          = $clog2(FIFO_DEPTH);
  localparam logic [14:0]   LAST_WORD   = 15'(FRAME_WORDS - 1);
  localparam logic [PW+1:0] DEPTH_C     = (PW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t        state_reg;
  logic [14:0]   addr_reg;
  logic [14:0]   cnt_reg;
  logic          inflight_reg;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic [15:0]   word_reg;
  logic          half_reg;
  logic          valid_reg;
  logic          underrun_reg;

  logic [PW+1:0] occupancy;
  logic          issue;
  logic          pop;
  logic          load;
  logic [PW-1:0] next_rd;

  // The unpack register mirrors the FIFO head; the word leaves the FIFO only once
  // its low half has been handed out, so the FIFO alone bounds the read-ahead.
  always_comb begin
    occupancy = {1'b0, count_reg} + {{(PW+1){1'b0}}, inflight_reg};
    issue     = (state_reg == FETCH) && bus.enable && (occupancy < DEPTH_C);
    pop       = valid_reg && half_reg && bus.pix_rd;
    load      = (!valid_reg && (count_reg != '0)) || (pop && (count_reg > (PW+1)'(1)));
    next_rd   = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
  end

  always_ff @(posedge clk) begin
    if (reset && !bus.frame_start && inflight_reg)
      fifo_mem[wr_ptr_reg] <= bus.vga_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      addr_reg     <= BASE_ADDR;
      cnt_reg      <= '0;
      inflight_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      word_reg     <= '0;
      half_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      underrun_reg <= 1'b0;
    end else if (bus.frame_start) begin
      // Restart the frame from any state; anything buffered or in flight is stale.
      state_reg    <= FETCH;
      addr_reg     <= BASE_ADDR;
      cnt_reg      <= '0;
      inflight_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      word_reg     <= '0;
      half_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        addr_reg <= addr_reg + 15'd1;
        cnt_reg  <= cnt_reg + 15'd1;
        if (cnt_reg == LAST_WORD)
          state_reg <= DONE;
      end

      if (inflight_reg)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      rd_ptr_reg <= next_rd;
      count_reg  <= count_reg + (PW+1)'(inflight_reg) - (PW+1)'(pop);

      if (load) begin
        word_reg  <= fifo_mem[next_rd];
        half_reg  <= 1'b0;
        valid_reg <= 1'b1;
      end else if (pop) begin
        valid_reg <= 1'b0;
      end else if (valid_reg && bus.pix_rd) begin
        half_reg <= 1'b1;
      end

      if (bus.pix_rd && !valid_reg)
        underrun_reg <= 1'b1;
    end
  end

  assign bus.vga_addr  = addr_reg;
  assign bus.pix_valid = valid_reg;
  assign bus.underrun  = underrun_reg;
  assign bus.pixel     = !valid_reg ? 8'h00 : (half_reg ? word_reg[7:0] : word_reg[15:8]);
endmodule
